urna_booth_scheduler: RTL

Round-robin scheduler that shares one `Urna` tally between `NBOOTH` voting booths. It accepts 4-bit ballot codes from the booths one at a time and sequences the `Urna` inputs: present digits, strobe `valid`, then wait for `VoteStatus`. It also performs an orderly session close by driving `finish`. It sits between the booth front-ends and the single `Urna` instance.

---
 rtl/urna_booth_scheduler_if.sv | 32 +++
 rtl/urna_booth_scheduler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/urna_booth_scheduler_if.sv
// Booth/Urna-facing signal bundle for urna_booth_scheduler.
// master = booths and Urna (testbench side), slave = the scheduler.
interface urna_booth_scheduler_if #(
    parameter int NBOOTH = 4
);
    logic [NBOOTH-1:0]   req;
    logic [4*NBOOTH-1:0] code;
    logic                close;
    logic [NBOOTH-1:0]   grant;
    logic                digit0;
    logic                digit1;
    logic                digit2;
    logic                digit3;
    logic                valid;
    logic                VoteStatus;
    logic                finish;
    logic                busy;
    logic [7:0]          votes_cast;
    logic [7:0]          timeouts;

    modport master (
        output req, code, close, VoteStatus,
        input  grant, digit0, digit1, digit2, digit3, valid, finish, busy,
               votes_cast, timeouts
    );

    modport slave (
        input  req, code, close, VoteStatus,
        output grant, digit0, digit1, digit2, digit3, valid, finish, busy,
               votes_cast, timeouts
    );
endinterface

// File: rtl/urna_booth_scheduler.sv
// Round-robin scheduler sharing one Urna tally between NBOOTH booths:
// grant, strobe valid, wait for VoteStatus (or time out), orderly close.
module urna_booth_scheduler #(
    parameter int NBOOTH  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    urna_booth_scheduler_if.slave  bus
);
    localparam int          PW = (NBOOTH > 1) ? $clog2(NBOOTH) : 1;
    localparam int unsigned NB = NBOOTH;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        CLOSED
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic              found;
    logic [NBOOTH-1:0] win_onehot;
    logic [3:0]        win_code;
    logic [3:0]        digits;
    logic [NBOOTH-1:0] grant;
    logic              valid;
    logic              finish;
    logic              busy;
    logic              pend_close;
    logic [7:0]        tcnt;
    logic [7:0]        votes_cast;
    logic [7:0]        timeouts;
    int unsigned       cand;

    // First requesting booth at or after ptr, wrapping around.
    always_comb begin
        found      = 1'b0;
        win        = '0;
        cand       = 0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NB) begin
                cand = cand - NB;
            end
            if (!found && bus.req[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
        win_onehot[win] = found;
        win_code        = bus.code[{win, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            grant      <= '0;
            digits     <= '0;
            valid      <= 1'b0;
            finish     <= 1'b0;
            busy       <= 1'b0;
            pend_close <= 1'b0;
            tcnt       <= '0;
            votes_cast <= '0;
            timeouts   <= '0;
        end else begin
            grant <= '0;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.close || pend_close) begin
                        state  <= CLOSED;
                        finish <= 1'b1;
                        digits <= '0;
                    end else if (found) begin
                        grant  <= win_onehot;
                        digits <= win_code;
                        ptr    <= (win == PW'(NBOOTH - 1)) ? '0 : win + 1'b1;
                        busy   <= 1'b1;
                        state  <= STROBE;
                    end
                end
                STROBE: begin
                    valid <= 1'b1;
                    tcnt  <= '0;
                    state <= WAIT;
                    if (bus.close) begin
                        pend_close <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.close) begin
                        pend_close <= 1'b1;
                    end
                    if (bus.VoteStatus) begin
                        if (votes_cast != 8'hFF) begin
                            votes_cast <= votes_cast + 8'd1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tcnt == 8'(TIMEOUT)) begin
                        if (timeouts != 8'hFF) begin
                            timeouts <= timeouts + 8'd1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                CLOSED: begin
                    finish <= 1'b1;
                    digits <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant      = grant;
    assign bus.digit0     = digits[0];
    assign bus.digit1     = digits[1];
    assign bus.digit2     = digits[2];
    assign bus.digit3     = digits[3];
    assign bus.valid      = valid;
    assign bus.finish     = finish;
    assign bus.busy       = busy;
    assign bus.votes_cast = votes_cast;
    assign bus.timeouts   = timeouts;
endmodule
